// File: rtl/fpro_uart_bus_master_if.sv
// Byte-stream and MMIO bus signals of the FPro UART bus master.
// The master modport is the bridge side; the slave modport is the UART/MMIO side.
interface fpro_uart_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mmio_cs;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, mmio_rd_data,
    output rx_ready, tx_data, tx_valid, mmio_cs, mmio_wr, mmio_rd,
           mmio_addr, mmio_wr_data, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mmio_rd_data,
    input  rx_ready, tx_data, tx_valid, mmio_cs, mmio_wr, mmio_rd,
           mmio_addr, mmio_wr_data, busy
  );
endinterface

// File: rtl/fpro_uart_bus_master.sv
// FPro MMIO bus initiator driven by a UART byte-stream command protocol.
// Frame: CMD, A2, A1, A0 [, D3, D2, D1, D0 for writes]; reply is ACK, NAK or 4 read bytes.
// Optional feature macro: BRIDGE_TIMEOUT_EN enables an inter-byte timeout that drops
// a partial frame after TIMEOUT_CYC idle cycles in the address/data phases.
module fpro_uart_bus_master #(
  parameter logic [7:0] CMD_WR      = 8'h57,
  parameter logic [7:0] CMD_RD      = 8'h52,
  parameter int         TIMEOUT_CYC = 100_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  fpro_uart_bus_master_if.master        bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic        op_wr;
  logic [20:0] addr_sr;
  logic [31:0] wdata_sr;
  logic [31:0] resp_sr;
  logic [2:0]  resp_left;

  logic rx_open;
  logic in_frame;
  logic rx_fire;
  logic tx_vld;
  logic tx_fire;
  logic strobe;
  logic tmo_hit;

  // Outputs are forced low during the reset cycle so no strobe or byte escapes it.
  assign in_frame = (state == S_ADDR) || (state == S_DATA);
  assign rx_open  = !reset && ((state == S_IDLE) || in_frame);
  assign rx_fire  = rx_open && bus.rx_valid;
  assign tx_vld   = !reset && (state == S_RESP);
  assign tx_fire  = tx_vld && bus.tx_ready;
  assign strobe   = !reset && (state == S_BUS);

  assign bus.rx_ready     = rx_open;
  assign bus.tx_valid     = tx_vld;
  assign bus.tx_data      = tx_vld ? resp_sr[31:24] : 8'h00;
  assign bus.mmio_cs      = strobe;
  assign bus.mmio_wr      = strobe && op_wr;
  assign bus.mmio_rd      = strobe && !op_wr;
  assign bus.mmio_addr    = addr_sr;
  assign bus.mmio_wr_data = wdata_sr;
  assign bus.busy         = !reset && (state != S_IDLE);

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_cnt;

  // Inter-byte idle counter: runs only while a frame is being received.
  always_ff @(posedge clk) begin
    if (reset || rx_fire || !in_frame) tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = in_frame && !rx_fire && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame parser, bus access sequencer and response serializer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      op_wr     <= 1'b0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      resp_sr   <= '0;
      resp_left <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
              op_wr    <= (bus.rx_data == CMD_WR);
              byte_cnt <= 2'd0;
              state    <= S_ADDR;
            end else begin
              resp_sr   <= {NAK, 24'h0};
              resp_left <= 3'd1;
              state     <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (tmo_hit) begin
            state <= S_IDLE;
          end else if (rx_fire) begin
            // Three shifts leave {A2[4:0], A1, A0}; A2[7:5] fall off the top.
            addr_sr <= {addr_sr[12:0], bus.rx_data};
            if (byte_cnt == 2'd2) begin
              byte_cnt <= 2'd0;
              state    <= op_wr ? S_DATA : S_BUS;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (tmo_hit) begin
            state <= S_IDLE;
          end else if (rx_fire) begin
            wdata_sr <= {wdata_sr[23:0], bus.rx_data};
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              state    <= S_BUS;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_BUS: begin
          resp_sr   <= op_wr ? {ACK, 24'h0} : bus.mmio_rd_data;
          resp_left <= op_wr ? 3'd1 : 3'd4;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (tx_fire) begin
            resp_sr   <= {resp_sr[23:0], 8'h00};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_uart_bus_master.sv
// Randomized self-checking bench for fpro_uart_bus_master.
// Expected bus accesses and reply bytes come from a frame-level model of the protocol.
module tb_fpro_uart_bus_master;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 100_000_000;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd_val;
  int          txr_mode;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // monitor state
  int          rx_hs = 0;
  int          strb_cnt = 0;
  int          bad_strb = 0;
  int          last_rx_cyc = 0;
  int          strb_cyc = 0;
  int          txv_cyc = 0;
  logic        txv_prev = 1'b0;
  logic        s_wr, s_rd;
  logic [20:0] s_addr;
  logic [31:0] s_data;
  bq_t         txq;

  fpro_uart_bus_master_if bus ();

  fpro_uart_bus_master #(
    .CMD_WR     (8'h57),
    .CMD_RD     (8'h52),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // responder drives read data only while the read strobe is up
  assign bus.mmio_rd_data = bus.mmio_rd ? rd_val : 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mmio_cs) begin
      strb_cnt++;
      strb_cyc = cyc;
      s_wr   = bus.mmio_wr;
      s_rd   = bus.mmio_rd;
      s_addr = bus.mmio_addr;
      s_data = bus.mmio_wr_data;
    end
    if ((bus.mmio_wr || bus.mmio_rd) && !bus.mmio_cs) bad_strb++;
    if (!reset) begin
      if (bus.rx_valid && bus.rx_ready) begin
        rx_hs++;
        last_rx_cyc = cyc;
      end
      if (bus.tx_valid && !txv_prev) txv_cyc = cyc;
      if (bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    end
    txv_prev = bus.tx_valid;
  end

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (txr_mode)
        1:       bus.tx_ready = 1'($urandom_range(0, 1));
        2:       bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk({tag, "_idle_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bq_t fr, input bit exp_strb, input bit exp_wr,
                           input logic [20:0] exp_addr, input logic [31:0] exp_data,
                           input bq_t exp_tx, input string tag);
    int s0 = strb_cnt;
    txq.delete();
    foreach (fr[i]) send_byte(fr[i]);
    wait_idle(tag);
    chk({tag, "_nstrobe"}, 32'(strb_cnt - s0), 32'(exp_strb));
    if (exp_strb) begin
      chk({tag, "_wr"}, 32'(s_wr), 32'(exp_wr));
      chk({tag, "_rd"}, 32'(s_rd), 32'(!exp_wr));
      chk({tag, "_addr"}, 32'(s_addr), 32'(exp_addr));
      if (exp_wr) chk({tag, "_wdata"}, s_data, exp_data);
      chk({tag, "_lat_bus"}, 32'(strb_cyc - last_rx_cyc), 1);
      chk({tag, "_lat_tx"}, 32'(txv_cyc - strb_cyc), 1);
    end
    chk({tag, "_ntx"}, 32'(txq.size()), 32'(exp_tx.size()));
    if (txq.size() == exp_tx.size())
      foreach (exp_tx[i]) chk({tag, "_txbyte"}, 32'(txq[i]), 32'(exp_tx[i]));
  endtask

  function automatic bq_t rd_reply(input logic [31:0] v);
    bq_t q;
    for (int k = 3; k >= 0; k--) q.push_back(8'((v >> (8 * k)) & 32'hFF));
    return q;
  endfunction

  initial begin
    bq_t         fr;
    bq_t         ex;
    logic [7:0]  tx_hold;
    int          s0;
    int          r0;
    int          n;
    logic [7:0]  b[8];
    logic [20:0] a;
    logic [31:0] d;

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rd_val       = 32'h0;
    txr_mode     = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_cs", 32'(bus.mmio_cs), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 1);
    chk("post_rst_addr", 32'(bus.mmio_addr), 0);
    chk("post_rst_wdata", bus.mmio_wr_data, 0);
    chk("post_rst_tx_data", 32'(bus.tx_data), 0);
    @(posedge clk);
    #1;

    // directed write
    fr = '{8'h57, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    ex = '{8'h06};
    run_frame(fr, 1, 1, 21'h000002, 32'hDEADBEEF, ex, "write");

    // directed read at top address
    rd_val = 32'h12345678;
    fr = '{8'h52, 8'h1F, 8'hFF, 8'hFF};
    run_frame(fr, 1, 0, 21'h1FFFFF, 32'h0, rd_reply(rd_val), "read");

    // bad command then a normal read
    fr = '{8'h41};
    ex = '{8'h15};
    run_frame(fr, 0, 0, 21'h0, 32'h0, ex, "badcmd");
    rd_val = 32'hA5C3_0F96;
    fr = '{8'h52, 8'h00, 8'h00, 8'h03};
    run_frame(fr, 1, 0, 21'h000003, 32'h0, rd_reply(rd_val), "after_nak");

    // backpressure during read reply with a pending rx byte
    txq.delete();
    s0 = strb_cnt;
    rd_val = 32'hCAFE_F00D;
    txr_mode = 2;
    @(posedge clk);
    #1;
    fr = '{8'h52, 8'h00, 8'h10, 8'h20};
    foreach (fr[i]) send_byte(fr[i]);
    n = 0;
    @(negedge clk);
    while (!bus.tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_tx_valid_seen", 32'(bus.tx_valid), 1);
    tx_hold = bus.tx_data;
    chk("bp_first_byte", 32'(tx_hold), 32'hCA);
    @(posedge clk);
    #1;
    bus.rx_data  = 8'h41;
    bus.rx_valid = 1'b1;
    r0 = rx_hs;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_data !== tx_hold || bus.tx_valid !== 1'b1 || bus.rx_ready !== 1'b0) begin
        chk("bp_tx_data_stable", 32'(bus.tx_data), 32'(tx_hold));
        chk("bp_tx_valid_held", 32'(bus.tx_valid), 1);
        chk("bp_rx_ready_low", 32'(bus.rx_ready), 0);
      end
    end
    chk("bp_stall_cycles_clean", 32'(bus.tx_data), 32'(tx_hold));
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    chk("bp_rx_not_consumed", 32'(rx_hs - r0), 0);
    txr_mode = 0;
    wait_idle("bp");
    chk("bp_nstrobe", 32'(strb_cnt - s0), 1);
    ex = rd_reply(rd_val);
    chk("bp_ntx", 32'(txq.size()), 4);
    if (txq.size() == 4)
      foreach (ex[i]) chk("bp_txbyte", 32'(txq[i]), 32'(ex[i]));

    // reset mid-frame
    txq.delete();
    s0 = strb_cnt;
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy_in_reset", 32'(bus.busy), 0);
    chk("midrst_cs_in_reset", 32'(bus.mmio_cs), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy_after", 32'(bus.busy), 0);
    chk("midrst_rx_ready_after", 32'(bus.rx_ready), 1);
    repeat (5) @(negedge clk);
    chk("midrst_no_strobe", 32'(strb_cnt - s0), 0);
    chk("midrst_no_tx", 32'(txq.size()), 0);
    @(posedge clk);
    #1;
    fr = '{8'h57, 8'h00, 8'h01, 8'h23, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    ex = '{8'h06};
    run_frame(fr, 1, 1, 21'h000123, 32'hCAFEBABE, ex, "midrst_write");

    // partial frame left idle; A2[7:5] set in the resumed/next frame
    txq.delete();
    s0 = strb_cnt;
    rd_val = 32'h0BAD_F00D;
    send_byte(8'h52);
    send_byte(8'hE0);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("partial_no_strobe", 32'(strb_cnt - s0), 0);
    chk("partial_no_tx", 32'(txq.size()), 0);
    @(posedge clk);
    #1;
`ifdef BRIDGE_TIMEOUT_EN
    chk("timeout_idle", 32'(n < 40), 1);
    fr = '{8'h52, 8'hE0, 8'h00, 8'h05};
    run_frame(fr, 1, 0, 21'h000005, 32'h0, rd_reply(rd_val), "after_timeout");
`else
    chk("no_timeout_still_busy", 32'(n >= 40), 1);
    fr = '{8'h00, 8'h05};
    run_frame(fr, 1, 0, 21'h000005, 32'h0, rd_reply(rd_val), "resumed");
`endif

    // randomized frames
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 2);
      txr_mode = $urandom_range(0, 1);
      for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
      rd_val = $urandom;
      a = 21'(((32'(b[1]) & 32'h1F) << 16) + (32'(b[2]) << 8) + 32'(b[3]));
      d = (32'(b[4]) << 24) + (32'(b[5]) << 16) + (32'(b[6]) << 8) + 32'(b[7]);
      fr.delete();
      if (kind == 0) begin
        fr = '{8'h57, b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
        ex = '{8'h06};
        run_frame(fr, 1, 1, a, d, ex, "rnd_write");
      end else if (kind == 1) begin
        fr = '{8'h52, b[1], b[2], b[3]};
        run_frame(fr, 1, 0, a, 32'h0, rd_reply(rd_val), "rnd_read");
      end else begin
        if (b[0] == 8'h57 || b[0] == 8'h52) b[0] = 8'h00;
        fr = '{b[0]};
        ex = '{8'h15};
        run_frame(fr, 0, 0, 21'h0, 32'h0, ex, "rnd_bad");
      end
    end

    chk("strobe_without_cs", 32'(bad_strb), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
